// File: rtl/cdf_accum_pkg.sv
// Shared constants and FSM encoding for the CDF accumulation stage.
package cdf_accum_pkg;

  localparam int NUM_WORDS     = 64;
  localparam int ADDR_W        = 16;
  localparam int BIN_W         = 32;
  localparam int BINS_PER_WORD = 4;
  localparam int WORD_W        = BIN_W * BINS_PER_WORD;
  localparam int IDX_W         = $clog2(NUM_WORDS);

  localparam logic [ADDR_W-1:0] HIST_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] CDF_BASE  = 16'h0040;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cdf_state_t;

endpackage

// File: rtl/cdf_accum_if.sv
// Dual-port scratch memory bus shared between the CDF stage and scratch memory.
interface cdf_accum_if;
  import cdf_accum_pkg::*;

  logic [WORD_W-1:0] cdf_sc_mem_rd_data;
  logic [ADDR_W-1:0] cdf_sc_mem_rd_addr;
  logic              cdf_sc_mem_rd_en;
  logic [ADDR_W-1:0] cdf_sc_mem_wt_addr;
  logic [WORD_W-1:0] cdf_sc_mem_wt_data;
  logic              cdf_sc_mem_wt_en;

  modport master (
    input  cdf_sc_mem_rd_data,
    output cdf_sc_mem_rd_addr,
    output cdf_sc_mem_rd_en,
    output cdf_sc_mem_wt_addr,
    output cdf_sc_mem_wt_data,
    output cdf_sc_mem_wt_en
  );

  modport slave (
    output cdf_sc_mem_rd_data,
    input  cdf_sc_mem_rd_addr,
    input  cdf_sc_mem_rd_en,
    input  cdf_sc_mem_wt_addr,
    input  cdf_sc_mem_wt_data,
    input  cdf_sc_mem_wt_en
  );

endinterface

// File: rtl/cdf_accum_prefix4.sv
// Four-lane prefix adder: turns one histogram word plus the incoming running
// sum into one CDF word, and reports the lowest lane whose CDF is nonzero.
module cdf_prefix4
  import cdf_accum_pkg::*;
(
  input  logic [BIN_W-1:0]  s,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] cdf_word,
  output logic              nz_valid,
  output logic [BIN_W-1:0]  nz_value
);

  logic [BIN_W-1:0] acc;

  // Ripple the running sum through the lanes, lane 0 (lowest bin) first.
  always_comb begin
    acc      = s;
    cdf_word = '0;
    nz_valid = 1'b0;
    nz_value = '0;
    for (int j = 0; j < BINS_PER_WORD; j++) begin
      acc = acc + word[j*BIN_W +: BIN_W];
      cdf_word[j*BIN_W +: BIN_W] = acc;
      if (!nz_valid && (acc != '0)) begin
        nz_valid = 1'b1;
        nz_value = acc;
      end
    end
  end

endmodule

// File: rtl/cdf_accum.sv
// Histogram-equalisation CDF stage: streams the histogram out of scratch
// memory, writes the cumulative distribution back, and reports the first
// nonzero CDF value and the grand total for the divider.
module cdf_accum
  import cdf_accum_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cdf_en,
  cdf_accum_if.master       mem,
  output logic [BIN_W-1:0]  cdf_min,
  output logic [BIN_W-1:0]  cdf_total,
  output logic              cdf_done
);

  cdf_state_t        state;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wt_idx;
  logic              data_valid;
  logic              wt_last;
  logic              min_found;
  logic [BIN_W-1:0]  run_sum;

  logic [WORD_W-1:0] cdf_word;
  logic              nz_valid;
  logic [BIN_W-1:0]  nz_value;

  cdf_prefix4 u_prefix4 (
    .s        (run_sum),
    .word     (mem.cdf_sc_mem_rd_data),
    .cdf_word (cdf_word),
    .nz_valid (nz_valid),
    .nz_value (nz_value)
  );

  // Control FSM plus read, accumulate and write pipeline, all frozen by enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                  <= ST_IDLE;
      rd_idx                 <= '0;
      wt_idx                 <= '0;
      data_valid             <= 1'b0;
      wt_last                <= 1'b0;
      min_found              <= 1'b0;
      run_sum                <= '0;
      mem.cdf_sc_mem_rd_en   <= 1'b0;
      mem.cdf_sc_mem_rd_addr <= '0;
      mem.cdf_sc_mem_wt_en   <= 1'b0;
      mem.cdf_sc_mem_wt_addr <= '0;
      mem.cdf_sc_mem_wt_data <= '0;
      cdf_min                <= '0;
      cdf_total              <= '0;
      cdf_done               <= 1'b0;
    end else if (enable) begin
      mem.cdf_sc_mem_rd_en <= 1'b0;
      mem.cdf_sc_mem_wt_en <= 1'b0;
      cdf_done             <= 1'b0;
      data_valid           <= mem.cdf_sc_mem_rd_en;
      wt_last              <= data_valid && (wt_idx == IDX_W'(NUM_WORDS - 1));

      if (data_valid) begin
        mem.cdf_sc_mem_wt_en   <= 1'b1;
        mem.cdf_sc_mem_wt_addr <= CDF_BASE + ADDR_W'(wt_idx);
        mem.cdf_sc_mem_wt_data <= cdf_word;
        wt_idx                 <= wt_idx + 1'b1;
        run_sum                <= cdf_word[WORD_W-1 -: BIN_W];
        if (!min_found && nz_valid) begin
          min_found <= 1'b1;
          cdf_min   <= nz_value;
        end
      end

      case (state)
        ST_IDLE: begin
          if (cdf_en) begin
            state     <= ST_RUN;
            rd_idx    <= '0;
            wt_idx    <= '0;
            run_sum   <= '0;
            min_found <= 1'b0;
            cdf_min   <= '0;
            cdf_total <= '0;
          end
        end
        ST_RUN: begin
          mem.cdf_sc_mem_rd_en   <= 1'b1;
          mem.cdf_sc_mem_rd_addr <= HIST_BASE + ADDR_W'(rd_idx);
          rd_idx                 <= rd_idx + 1'b1;
          if (rd_idx == IDX_W'(NUM_WORDS - 1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (wt_last) begin
            state     <= ST_DONE;
            cdf_done  <= 1'b1;
            cdf_total <= run_sum;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_accum.sv
// Directed testbench for cdf_accum with a dual-port scratch memory model.
module tb_cdf_accum;
  import cdf_accum_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic cdf_en = 1'b0;
  logic [BIN_W-1:0] cdf_min;
  logic [BIN_W-1:0] cdf_total;
  logic cdf_done;

  cdf_accum_if mem_if ();

  cdf_accum u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cdf_en    (cdf_en),
    .mem       (mem_if),
    .cdf_min   (cdf_min),
    .cdf_total (cdf_total),
    .cdf_done  (cdf_done)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] scratch [128];
  logic [BIN_W-1:0]  hist_bin [256];

  int tests_run = 0;
  int tests_failed = 0;
  int edge_cnt = 0;
  int t0 = 0;

  int wr_count, rd_count, done_count, done_at, first_wr, last_wr, first_rd;
  logic [ADDR_W-1:0] wr_addr_log [128];
  logic [ADDR_W-1:0] rd_addr_log [128];

  // Scratch memory: one-cycle read latency, writes commit at the edge, stalled by enable.
  always @(posedge clk) begin
    if (enable) begin
      if (mem_if.cdf_sc_mem_rd_en)
        mem_if.cdf_sc_mem_rd_data <= scratch[mem_if.cdf_sc_mem_rd_addr[6:0]];
      if (mem_if.cdf_sc_mem_wt_en)
        scratch[mem_if.cdf_sc_mem_wt_addr[6:0]] = mem_if.cdf_sc_mem_wt_data;
    end
  end

  // Count clock edges so cycles can be reported relative to the start edge.
  always @(posedge clk) edge_cnt++;

  // Log accepted strobes and done pulses mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (enable && mem_if.cdf_sc_mem_wt_en) begin
      if (wr_count == 0) first_wr = edge_cnt - t0;
      last_wr = edge_cnt - t0;
      if (wr_count < 128) wr_addr_log[wr_count] = mem_if.cdf_sc_mem_wt_addr;
      wr_count++;
    end
    if (enable && mem_if.cdf_sc_mem_rd_en) begin
      if (rd_count == 0) first_rd = edge_cnt - t0;
      if (rd_count < 128) rd_addr_log[rd_count] = mem_if.cdf_sc_mem_rd_addr;
      rd_count++;
    end
    if (cdf_done) begin
      done_count++;
      done_at = edge_cnt - t0;
    end
  end

  task automatic checkOutput(input string tag, input logic [WORD_W-1:0] got,
                             input logic [WORD_W-1:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Fill histogram words from a bin pattern and poison the CDF region.
  task automatic loadHistogram(input int mode);
    for (int b = 0; b < 256; b++) begin
      case (mode)
        0: hist_bin[b] = 32'd1;
        1: hist_bin[b] = (b == 10) ? 32'd7 : (b == 255) ? 32'd5 : 32'd0;
        2: hist_bin[b] = 32'd0;
        default: hist_bin[b] = 32'h0100_0000;
      endcase
    end
    for (int w = 0; w < 64; w++) begin
      scratch[w] = {hist_bin[4*w+3], hist_bin[4*w+2], hist_bin[4*w+1], hist_bin[4*w]};
      scratch[64+w] = {4{32'hDEAD_BEEF}};
    end
  endtask

  task automatic clearLogs();
    wr_count = 0; rd_count = 0; done_count = 0; done_at = -1;
    first_wr = -1; last_wr = -1; first_rd = -1;
  endtask

  task automatic startRun();
    @(posedge clk); #2;
    cdf_en = 1'b1;
    @(posedge clk); #2;
    cdf_en = 1'b0;
    t0 = edge_cnt;
  endtask

  // Run one job to completion, optionally stalling or re-pulsing cdf_en, then check it.
  task automatic applyStimulus(input string name, input int mode,
                               input logic [BIN_W-1:0] exp_min,
                               input logic [BIN_W-1:0] exp_total,
                               input int exp_done, input int stall_at,
                               input int repulse_at);
    int rel;
    int addr_errs;
    int data_errs;
    logic [BIN_W-1:0] sum;
    logic [WORD_W-1:0] exp_word;
    loadHistogram(mode);
    clearLogs();
    startRun();
    for (int c = 0; c < 200 && done_count == 0; c++) begin
      @(posedge clk); #2;
      rel = edge_cnt - t0;
      if (rel == stall_at) enable = 1'b0;
      if (rel == stall_at + 5) enable = 1'b1;
      cdf_en = (rel == repulse_at);
    end
    enable = 1'b1;
    cdf_en = 1'b0;
    checkOutput({name, "_done_seen"}, WORD_W'(done_count), WORD_W'(1));
    checkOutput({name, "_done_cycle"}, WORD_W'(done_at), WORD_W'(exp_done));
    checkOutput({name, "_done_low"}, WORD_W'(cdf_done), WORD_W'(0));
    checkOutput({name, "_cdf_min"}, WORD_W'(cdf_min), WORD_W'(exp_min));
    checkOutput({name, "_cdf_total"}, WORD_W'(cdf_total), WORD_W'(exp_total));
    checkOutput({name, "_wr_count"}, WORD_W'(wr_count), WORD_W'(64));
    checkOutput({name, "_rd_count"}, WORD_W'(rd_count), WORD_W'(64));
    checkOutput({name, "_first_rd"}, WORD_W'(first_rd), WORD_W'(1));
    checkOutput({name, "_first_wr"}, WORD_W'(first_wr), WORD_W'(3));
    checkOutput({name, "_last_wr"}, WORD_W'(last_wr), WORD_W'(exp_done - 1));
    addr_errs = 0;
    for (int k = 0; k < 64; k++) begin
      if (rd_addr_log[k] !== 16'(k)) addr_errs++;
      if (wr_addr_log[k] !== 16'(64 + k)) addr_errs++;
    end
    checkOutput({name, "_addr_order_errs"}, WORD_W'(addr_errs), WORD_W'(0));
    data_errs = 0;
    sum = '0;
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 4; j++) begin
        sum = sum + hist_bin[4*k+j];
        exp_word[32*j +: 32] = sum;
      end
      if (scratch[64+k] !== exp_word) data_errs++;
    end
    checkOutput({name, "_cdf_word_errs"}, WORD_W'(data_errs), WORD_W'(0));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_rd_en", WORD_W'(mem_if.cdf_sc_mem_rd_en), WORD_W'(0));
    checkOutput("reset_wt_en", WORD_W'(mem_if.cdf_sc_mem_wt_en), WORD_W'(0));
    checkOutput("reset_done", WORD_W'(cdf_done), WORD_W'(0));
    checkOutput("reset_total", WORD_W'(cdf_total), WORD_W'(0));
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // All ones.
    applyStimulus("ones", 0, 32'd1, 32'd256, 67, -100, -100);
    checkOutput("ones_word0", scratch[64],
                128'h00000004_00000003_00000002_00000001);
    checkOutput("ones_word63", scratch[127],
                128'h00000100_000000FF_000000FE_000000FD);

    // Sparse histogram.
    applyStimulus("sparse", 1, 32'd7, 32'd12, 67, -100, -100);
    checkOutput("sparse_word1", scratch[65], 128'h0);
    checkOutput("sparse_word2", scratch[66],
                128'h00000007_00000007_00000000_00000000);
    checkOutput("sparse_word63", scratch[127],
                128'h0000000C_00000007_00000007_00000007);

    // All zero.
    applyStimulus("zero", 2, 32'd0, 32'd0, 67, -100, -100);
    checkOutput("zero_word40", scratch[104], 128'h0);

    // Wrapping sum.
    applyStimulus("wrap", 3, 32'h0100_0000, 32'd0, 67, -100, -100);
    checkOutput("wrap_bin255", WORD_W'(scratch[127][127:96]), WORD_W'(32'h0));
    checkOutput("wrap_bin254", WORD_W'(scratch[127][95:64]), WORD_W'(32'hFF00_0000));

    // Five-cycle stall while reading word 20.
    applyStimulus("stall", 0, 32'd1, 32'd256, 72, 20, -100);

    // Start re-pulsed mid-run.
    applyStimulus("repulse", 0, 32'd1, 32'd256, 67, -100, 10);

    // Reset mid-run, then a fresh run.
    begin
      int wr_at_reset;
      int rel;
      loadHistogram(0);
      clearLogs();
      startRun();
      rel = 0;
      for (int c = 0; c < 100 && rel < 29; c++) begin
        @(posedge clk); #2;
        rel = edge_cnt - t0;
      end
      reset = 1'b0;
      @(posedge clk); #2;
      wr_at_reset = wr_count;
      checkOutput("abort_rd_en", WORD_W'(mem_if.cdf_sc_mem_rd_en), WORD_W'(0));
      checkOutput("abort_wt_en", WORD_W'(mem_if.cdf_sc_mem_wt_en), WORD_W'(0));
      checkOutput("abort_wt_data", mem_if.cdf_sc_mem_wt_data, 128'h0);
      checkOutput("abort_wt_addr", WORD_W'(mem_if.cdf_sc_mem_wt_addr), WORD_W'(0));
      checkOutput("abort_cdf_min", WORD_W'(cdf_min), WORD_W'(0));
      reset = 1'b1;
      repeat (80) @(posedge clk);
      #2;
      checkOutput("abort_no_writes", WORD_W'(wr_count), WORD_W'(wr_at_reset));
      checkOutput("abort_no_done", WORD_W'(done_count), WORD_W'(0));
    end
    applyStimulus("rerun", 0, 32'd1, 32'd256, 67, -100, -100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
